// File: rtl/axis_pkt_pkg.sv
// Shared types and default widths for the AXI-Stream packet source.
package axis_pkt_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;
  localparam int GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } pkt_state_t;

endpackage

// File: rtl/axis_pkt_source.sv
// AXI-Stream master that emits one incrementing-byte packet per start request,
// then idles for a programmable gap. Every output is a flop.
module axis_pkt_source
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W = axis_pkt_pkg::DATA_W,
  parameter int LEN_W  = axis_pkt_pkg::LEN_W,
  parameter int GAP_W  = axis_pkt_pkg::GAP_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] seed,
  input  logic [GAP_W-1:0]  gap,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_count
);

  pkt_state_t       state, state_d;
  logic [LEN_W-1:0] remaining;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             fire;
  logic             final_beat;

  assign accept     = (state == IDLE) && start && (pkt_len != '0);
  assign fire       = m_tvalid && m_tready;
  assign final_beat = fire && (remaining == LEN_W'(1));

  // NOTE: state_d is given a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (final_beat) state_d = (gap_cnt != '0) ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      remaining <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_count <= '0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
      done  <= final_beat;
      if (final_beat) pkt_count <= pkt_count + 16'd1;

      unique case (state)
        IDLE: begin
          if (accept) begin
            m_tdata   <= seed;
            remaining <= pkt_len;
            gap_cnt   <= gap;
            m_tvalid  <= 1'b1;
            m_tlast   <= (pkt_len == LEN_W'(1));
          end
        end
        SEND: begin
          // tdata/tlast only move on a handshake, so they hold while stalled.
          if (fire) begin
            m_tdata   <= m_tdata + DATA_W'(1);
            remaining <= remaining - LEN_W'(1);
            m_tlast   <= (remaining == LEN_W'(2));
            if (final_beat) begin
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_source.sv
// Scoreboard bench: the driver queues the beats each accepted request should
// produce, and a negedge monitor pops and compares on every handshake.
module tb_axis_pkt_source;
  import axis_pkt_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int GW = 4;

  logic          aclk     = 1'b0;
  logic          aresetn  = 1'b0;
  logic          start    = 1'b0;
  logic [LW-1:0] pkt_len  = '0;
  logic [DW-1:0] seed     = '0;
  logic [GW-1:0] gap      = '0;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          busy;
  logic          done;
  logic [15:0]   pkt_count;

  axis_pkt_source #(.DATA_W(DW), .LEN_W(LW), .GAP_W(GW)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .pkt_len   (pkt_len),
    .seed      (seed),
    .gap       (gap),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .busy      (busy),
    .done      (done),
    .pkt_count (pkt_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests    = 0;
  int    n_fail     = 0;
  int    beats_seen = 0;
  int    exp_pkts   = 0;
  int    ready_mode = 0;
  int    pat_idx    = 0;
  bit    pat [6]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Monitor state
  bit            prev_stall   = 1'b0;
  logic [DW-1:0] prev_data    = '0;
  logic          prev_last    = 1'b0;
  bit            last_hs_prev = 1'b0;
  bit            last_hs      = 1'b0;
  bit            have_prev    = 1'b0;
  int            idle_run     = 0;
  int            min_idle     = 0;
  beat_t         mb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always-on, random, or the fixed toggle pattern.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 9) < 7);
        default: begin
          m_tready = (pat_idx < 6) ? pat[pat_idx] : 1'b1;
          pat_idx++;
        end
      endcase
    end
  end

  // Monitor: handshake scoreboard, stall stability, done timing, gap spacing.
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall   = 1'b0;
        last_hs_prev = 1'b0;
        have_prev    = 1'b0;
        idle_run     = 0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid", m_tvalid, 1);
          check("stall_tdata", m_tdata, prev_data);
          check("stall_tlast", m_tlast, prev_last);
        end
        if (last_hs_prev || done) check("done_pulse", done, last_hs_prev);
        if (done) check("pkt_count_at_done", pkt_count, exp_pkts & 32'hFFFF);
        if (m_tvalid) begin
          check("busy_with_valid", busy, 1);
          if (have_prev) begin
            check("idle_gap_ok", idle_run >= min_idle, 1);
            have_prev = 1'b0;
          end
        end else if (have_prev) begin
          idle_run++;
        end
        last_hs = 1'b0;
        if (m_tvalid && m_tready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", m_tdata, 32'hDEAD);
          end else begin
            mb = exp_q.pop_front();
            check("tdata", m_tdata, mb.data);
            check("tlast", m_tlast, mb.last);
            if (mb.last) begin
              exp_pkts++;
              have_prev = 1'b1;
              idle_run  = 0;
              min_idle  = mb.gap + 1;
              last_hs   = 1'b1;
            end
          end
        end
        prev_stall   = m_tvalid && !m_tready;
        prev_data    = m_tdata;
        prev_last    = m_tlast;
        last_hs_prev = last_hs;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge aclk);
      #2;
      n++;
    end while (busy && n < 1000);
    if (busy) check("wait_idle_timeout", busy, 0);
  endtask

  // Issue one request; non-zero lengths push their expected beats.
  task automatic send_pkt(input int len, input logic [DW-1:0] sd, input int g);
    beat_t b;
    wait_idle();
    start   = 1'b1;
    pkt_len = LW'(len);
    seed    = sd;
    gap     = GW'(g);
    pat_idx = 0;
    for (int i = 0; i < len; i++) begin
      b.data = DW'(int'(sd) + i);
      b.last = (i == len - 1);
      b.gap  = g;
      exp_q.push_back(b);
    end
    @(posedge aclk);
    #2;
    start   = 1'b0;
    pkt_len = LW'($urandom);
    seed    = DW'($urandom);
    gap     = GW'($urandom);
  endtask

  task automatic wait_done(output int vcyc);
    int n = 0;
    vcyc = 0;
    while (!done && n < 2000) begin
      if (m_tvalid) vcyc++;
      @(posedge aclk);
      #2;
      n++;
    end
    if (!done) check("done_timeout", done, 1);
  endtask

  initial begin
    int vc;
    int b0;
    int n;

    // Reset values
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #2;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pkt_count", pkt_count, 0);
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #2;
    check("idle_tvalid", m_tvalid, 0);
    check("idle_busy", busy, 0);

    // Basic 4-beat packet, ready held high
    ready_mode = 0;
    send_pkt(4, 8'h10, 0);
    wait_done(vc);
    check("basic_valid_cycles", vc, 4);
    check("basic_pkt_count", pkt_count, 1);

    // Backpressure with the fixed ready pattern across the 0xFF wrap
    b0 = beats_seen;
    ready_mode = 2;
    send_pkt(3, 8'hFE, 0);
    wait_done(vc);
    check("bp_handshakes", beats_seen - b0, 3);

    // Single-beat packet
    ready_mode = 0;
    b0 = beats_seen;
    send_pkt(1, 8'h5A, 3);
    wait_done(vc);
    check("len1_valid_cycles", vc, 1);
    check("len1_handshakes", beats_seen - b0, 1);

    // Zero length request is ignored
    wait_idle();
    start   = 1'b1;
    pkt_len = '0;
    seed    = 8'h33;
    @(posedge aclk);
    #2;
    start = 1'b0;
    repeat (3) begin
      check("len0_busy", busy, 0);
      check("len0_tvalid", m_tvalid, 0);
      @(posedge aclk);
      #2;
    end
    check("len0_pkt_count", pkt_count, exp_pkts);

    // Gap of 5 with start pulses ignored during SEND and GAP
    send_pkt(3, DW'($urandom), 5);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      start   = 1'b1;
      pkt_len = LW'($urandom_range(1, 9));
      @(posedge aclk);
      #2;
    end
    start = 1'b0;
    send_pkt(2, DW'($urandom), 0);
    wait_done(vc);
    check("gap_pkt_count", pkt_count, exp_pkts);

    // Abort a 6-beat packet after its second beat
    b0 = beats_seen;
    send_pkt(6, 8'hC0, 0);
    n = 0;
    while (beats_seen < b0 + 2 && n < 100) begin
      @(posedge aclk);
      #2;
      n++;
    end
    check("abort_reached_beat2", beats_seen - b0, 2);
    aresetn = 1'b0;
    #1;
    exp_q.delete();
    exp_pkts = 0;
    check("abort_tvalid", m_tvalid, 0);
    check("abort_busy", busy, 0);
    check("abort_pkt_count", pkt_count, 0);
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    send_pkt(5, 8'hF0, 2);
    wait_done(vc);
    check("post_abort_pkt_count", pkt_count, 1);

    // Randomised packets and ready patterns
    for (int k = 0; k < 40; k++) begin
      ready_mode = int'($urandom_range(0, 1));
      send_pkt(int'($urandom_range(0, 12)), DW'($urandom), int'($urandom_range(0, 15)));
    end
    ready_mode = 1;
    wait_idle();
    repeat (5) @(posedge aclk);
    #2;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_pkt_count", pkt_count, exp_pkts & 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
